// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter that shares one external W-bit add/sub unit among NREQ requesters.
// One operation in flight at a time: IDLE (arbitrate) -> EXEC (adder settles) -> DONE (handshake).
module addsub_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] op_a_i,
    input  logic [NREQ*W-1:0] op_b_i,
    input  logic [NREQ-1:0]   op_sub_i,
    input  logic [NREQ-1:0]   op_sign_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              busy_o,
    output logic [W-1:0]      add_a_o,
    output logic [W-1:0]      add_b_o,
    output logic              add_sub_o,
    output logic              add_sign_o,
    input  logic [W-1:0]      add_sum_i,
    input  logic              add_ovf_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [IDW-1:0]    res_id_o,
    output logic [W-1:0]      res_sum_o,
    output logic              res_ovf_o
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
    logic            add_sub_q, add_sub_d, add_sign_q, add_sign_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [W-1:0]    res_sum_q, res_sum_d;
    logic            res_ovf_q, res_ovf_d;

    // Rotate requests so bit 0 is the requester at the round-robin pointer.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              win_found;
    logic [IDW-1:0]    win_idx;

    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        int unsigned pos;
        pos       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pos = 32'(ptr_q) + 32'(k);
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                win_found = 1'b1;
                win_idx   = IDW'(pos);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_sub_d   = add_sub_q;
        add_sign_d  = add_sign_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_ovf_d   = res_ovf_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d      = NREQ'(1) << win_idx;
                    add_a_d    = op_a_i[win_idx*W +: W];
                    add_b_d    = op_b_i[win_idx*W +: W];
                    add_sub_d  = op_sub_i[win_idx];
                    add_sign_d = op_sign_i[win_idx];
                    res_id_d   = win_idx;
                    ptr_d      = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                res_sum_d   = add_sum_i;
                res_ovf_d   = add_ovf_i;
                res_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_sub_q   <= 1'b0;
            add_sign_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_sum_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_sub_q   <= add_sub_d;
            add_sign_q  <= add_sign_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = (state_q != StIdle);
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_sub_o   = add_sub_q;
    assign add_sign_o  = add_sign_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_sum_o   = res_sum_q;
    assign res_ovf_o   = res_ovf_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Self-checking bench for addsub_share_arbiter with a bit-level shared adder attached
// and an arithmetic reference model for arbitration order and results.
module tb_addsub_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*W-1:0] op_a_i, op_b_i;
    logic [NREQ-1:0]   op_sub_i, op_sign_i;
    logic [NREQ-1:0]   gnt_o;
    logic              busy_o;
    logic [W-1:0]      add_a_o, add_b_o;
    logic              add_sub_o, add_sign_o;
    logic [W-1:0]      add_sum_i;
    logic              add_ovf_i;
    logic              res_valid_o, res_ready_i;
    logic [IDW-1:0]    res_id_o;
    logic [W-1:0]      res_sum_o;
    logic              res_ovf_o;

    always #5 clk = ~clk;

    addsub_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .op_sub_i    (op_sub_i),
        .op_sign_i   (op_sign_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_sub_o   (add_sub_o),
        .add_sign_o  (add_sign_o),
        .add_sum_i   (add_sum_i),
        .add_ovf_i   (add_ovf_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_id_o    (res_id_o),
        .res_sum_o   (res_sum_o),
        .res_ovf_o   (res_ovf_o)
    );

    // Shared adder: carry-chain view of the operation.
    logic [W-1:0] bx;
    logic [W:0]   s_full;
    logic         cmsb;
    always_comb begin
        bx        = add_sub_o ? ~add_b_o : add_b_o;
        s_full    = {1'b0, add_a_o} + {1'b0, bx} + {{W{1'b0}}, add_sub_o};
        cmsb      = add_a_o[W-1] ^ bx[W-1] ^ s_full[W-1];
        add_sum_i = s_full[W-1:0];
        add_ovf_i = (add_sub_o || add_sign_o) ? (cmsb ^ s_full[W]) : s_full[W];
    end

    int n_chk  = 0;
    int n_fail = 0;
    int ptr_m  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_winner(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, b, input logic s);
        int r;
        r = s ? int'(a) - int'(b) : int'(a) + int'(b);
        return r[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic s, sg);
        int sa, sb, r;
        if (!s && !sg) return (int'(a) + int'(b)) > 65535;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = s ? sa - sb : sa + sb;
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic set_slot(input int i, input logic [W-1:0] a, b, input logic s, sg);
        op_a_i[i*W +: W] = a;
        op_b_i[i*W +: W] = b;
        op_sub_i[i]      = s;
        op_sign_i[i]     = sg;
    endtask

    // Called just after an edge with the DUT idle; r is sampled at the next edge.
    task automatic run_op(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] junk,
                          input int w, input logic [W-1:0] es, input logic eo, input int delay);
        logic [W-1:0] a, b;
        logic         s, sg;
        a  = op_a_i[w*W +: W];
        b  = op_b_i[w*W +: W];
        s  = op_sub_i[w];
        sg = op_sign_i[w];
        req_i = r;
        @(posedge clk); #1;
        check({tag, " gnt"}, 64'(gnt_o), 64'(1) << w);
        check({tag, " busy"}, 64'(busy_o), 64'(1));
        check({tag, " add_ops"}, {30'd0, s, sg, a, b}, {30'd0, add_sub_o, add_sign_o, add_a_o, add_b_o});
        ptr_m = (w + 1) % NREQ;
        req_i = junk;
        @(posedge clk); #1;
        check({tag, " gnt_pulse"}, 64'(gnt_o), 64'(0));
        check({tag, " valid"}, 64'(res_valid_o), 64'(1));
        check({tag, " id"}, 64'(res_id_o), 64'(w));
        check({tag, " sum"}, 64'(res_sum_o), 64'(es));
        check({tag, " ovf"}, 64'(res_ovf_o), 64'(eo));
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
            check({tag, " hold"}, {res_valid_o, gnt_o, 2'(res_id_o), res_sum_o, res_ovf_o},
                  {1'b1, 4'b0000, 2'(w), es, eo});
        end
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        check({tag, " release"}, {62'd0, res_valid_o, busy_o}, 64'(0));
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [W-1:0]    a, b;
        logic            sub, sign;
        int              id;
        logic [W-1:0]    sum;
        logic            ovf;
        int              delay;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0001, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 16'h8000, 1'b1, 0};
        vecs[1] = '{4'b0100, 16'h0005, 16'h0003, 1'b1, 1'b0, 2, 16'h0002, 1'b0, 3};
        vecs[2] = '{4'b0010, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 0};
        vecs[3] = '{4'b1000, 16'h8000, 16'h0001, 1'b1, 1'b1, 3, 16'h7FFF, 1'b1, 1};
        vecs[4] = '{4'b0010, 16'h1234, 16'h1111, 1'b0, 1'b0, 1, 16'h2345, 1'b0, 0};
        vecs[5] = '{4'b0001, 16'h0003, 16'h0005, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0, 2};
        vecs[6] = '{4'b1000, 16'h8000, 16'h8000, 1'b0, 1'b1, 3, 16'h0000, 1'b1, 0};
        vecs[7] = '{4'b0100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2, 16'hFFFE, 1'b1, 0};

        rst_n       = 1'b0;
        req_i       = '0;
        op_a_i      = '0;
        op_b_i      = '0;
        op_sub_i    = '0;
        op_sign_i   = '0;
        res_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {gnt_o, busy_o, add_a_o, add_b_o, add_sub_o, add_sign_o,
                                res_valid_o, res_id_o, res_sum_o, res_ovf_o}, 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            op_a_i = {$urandom, $urandom};
            op_b_i = {$urandom, $urandom};
            set_slot(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sign);
            run_op($sformatf("vec%0d", i), vecs[i].req, 4'b0000, vecs[i].id, vecs[i].sum,
                   vecs[i].ovf, vecs[i].delay);
        end

        // Reset asserted while the operation is in EXEC drops it.
        set_slot(1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        req_i = 4'b0010;
        @(posedge clk); #1;
        req_i = '0;
        check("pre-reset gnt", 64'(gnt_o), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {gnt_o, busy_o, add_a_o, add_b_o, add_sub_o, add_sign_o,
                              res_valid_o, res_id_o, res_sum_o, res_ovf_o}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle after reset", {62'd0, res_valid_o, busy_o}, 64'(0));
        end

        // Round robin with all requests held high.
        for (int i = 0; i < NREQ; i++) begin
            set_slot(i, 16'(100 * (i + 1)), 16'(i + 1), 1'b0, 1'b0);
        end
        for (int n = 0; n < 5; n++) begin
            run_op($sformatf("rr%0d", n), 4'b1111, 4'b1111, n % NREQ,
                   16'(101 * ((n % NREQ) + 1)), 1'b0, 0);
        end

        // Backpressure with other requests pending in DONE, then requester 1 next.
        run_op("bp", 4'b0110, 4'b0110, 1, 16'(202), 1'b0, 5);
        check("ptr after bp", 64'(ptr_m), 64'(2));

        // Wrap from pointer 3 back to 0.
        run_op("wrap_pre", 4'b0100, 4'b0000, 2, 16'(303), 1'b0, 0);
        run_op("wrap3", 4'b1001, 4'b1001, 3, 16'(404), 1'b0, 0);
        run_op("wrap0", 4'b1001, 4'b0000, 0, 16'(101), 1'b0, 0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] r;
            int              w, dly;
            op_a_i    = {$urandom, $urandom};
            op_b_i    = {$urandom, $urandom};
            op_sub_i  = 4'($urandom);
            op_sign_i = 4'($urandom);
            r         = 4'($urandom_range(1, 15));
            w         = ref_winner(r);
            dly       = int'($urandom_range(0, 3));
            if (dly == 0 && $urandom_range(0, 1) == 1) res_ready_i = 1'b1;
            run_op($sformatf("rnd%0d", n), r, 4'($urandom), w,
                   ref_sum(op_a_i[w*W +: W], op_b_i[w*W +: W], op_sub_i[w]),
                   ref_ovf(op_a_i[w*W +: W], op_b_i[w*W +: W], op_sub_i[w], op_sign_i[w]), dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
